// File: rtl/freq_comp_rotator.sv
// Rotates each complex sample by its 3.13 phase with a quadrant pre-map plus a pipelined rotation-mode CORDIC.
// Define FREQ_COMP_ROTATOR_GAIN_COMP_EN to add a registered 1/1.6468 gain-compensation stage (+1 latency).
module freq_comp_rotator #(
  parameter int            DW      = 16,
  parameter int            PW      = 16,
  parameter int            STAGES  = 14,
  parameter int            GW      = 2,
  parameter logic [PW-1:0] PI_HALF = 16'h3244,
  parameter logic [PW-1:0] PI_VAL  = 16'h6488
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          din_nd,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] din_q,
  input  logic [PW-1:0] phase_in,
  output logic [DW-1:0] dout_i,
  output logic [DW-1:0] dout_q,
  output logic          dout_rdy
);

  localparam int XW = DW + GW;

  typedef logic signed [XW-1:0] xw_t;
  typedef logic signed [PW-1:0] zw_t;

  localparam xw_t OUT_MAX = xw_t'(2 ** (DW - 1) - 1);
  localparam xw_t OUT_MIN = xw_t'(-(2 ** (DW - 1)));

  function automatic zw_t atan_of(input int i);
    case (i)
      0:       atan_of = zw_t'(16'h1922);
      1:       atan_of = zw_t'(16'h0ED6);
      2:       atan_of = zw_t'(16'h07D7);
      3:       atan_of = zw_t'(16'h03FB);
      4:       atan_of = zw_t'(16'h01FF);
      5:       atan_of = zw_t'(16'h0100);
      6:       atan_of = zw_t'(16'h0080);
      7:       atan_of = zw_t'(16'h0040);
      8:       atan_of = zw_t'(16'h0020);
      9:       atan_of = zw_t'(16'h0010);
      10:      atan_of = zw_t'(16'h0008);
      11:      atan_of = zw_t'(16'h0004);
      12:      atan_of = zw_t'(16'h0002);
      13:      atan_of = zw_t'(16'h0001);
      default: atan_of = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] sat(input xw_t v);
    if (v > OUT_MAX)      sat = OUT_MAX[DW-1:0];
    else if (v < OUT_MIN) sat = OUT_MIN[DW-1:0];
    else                  sat = v[DW-1:0];
  endfunction

  // Index 0 is the pre-map register; index s+1 is the output of micro-rotation s.
  xw_t           x_q [STAGES+1];
  xw_t           x_d [STAGES+1];
  xw_t           y_q [STAGES+1];
  xw_t           y_d [STAGES+1];
  zw_t           z_q [STAGES];
  zw_t           z_d [STAGES];
  logic [STAGES:0] v_q, v_d;

  zw_t ph;
  xw_t in_x, in_y;

  assign ph   = zw_t'(phase_in);
  assign in_x = xw_t'($signed(din_i));
  assign in_y = xw_t'($signed(din_q));
  assign v_d  = {v_q[STAGES-1:0], din_nd};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    x_d[0] = in_x;
    y_d[0] = in_y;
    z_d[0] = ph;
    if (ph > zw_t'(PI_HALF)) begin
      z_d[0] = ph - zw_t'(PI_VAL);
      x_d[0] = -in_x;
      y_d[0] = -in_y;
    end else if (ph < -zw_t'(PI_HALF)) begin
      z_d[0] = ph + zw_t'(PI_VAL);
      x_d[0] = -in_x;
      y_d[0] = -in_y;
    end
    for (int s = 0; s < STAGES; s++) begin
      if (!z_q[s][PW-1]) begin
        x_d[s+1] = x_q[s] - (y_q[s] >>> s);
        y_d[s+1] = y_q[s] + (x_q[s] >>> s);
      end else begin
        x_d[s+1] = x_q[s] + (y_q[s] >>> s);
        y_d[s+1] = y_q[s] - (x_q[s] >>> s);
      end
    end
    // The residual angle after the final micro-rotation is never consumed.
    for (int s = 0; s < STAGES - 1; s++) begin
      z_d[s+1] = z_q[s][PW-1] ? z_q[s] + atan_of(s) : z_q[s] - atan_of(s);
    end
  end

  // NOTE: data registers are cleared on reset as well, so a reset leaves no stale samples anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int s = 0; s <= STAGES; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
      end
      for (int s = 0; s < STAGES; s++) begin
        z_q[s] <= '0;
      end
    end else if (ce) begin
      v_q <= v_d;
      for (int s = 0; s <= STAGES; s++) begin
        x_q[s] <= x_d[s];
        y_q[s] <= y_d[s];
      end
      for (int s = 0; s < STAGES; s++) begin
        z_q[s] <= z_d[s];
      end
    end
  end

  xw_t  fin_x, fin_y;
  logic fin_v;

`ifdef FREQ_COMP_ROTATOR_GAIN_COMP_EN
  localparam int MW = XW + 16;
  localparam logic signed [MW-1:0] K_GAIN = MW'(16'sh4DBA);
  localparam logic signed [MW-1:0] RND    = MW'(2 ** 14);

  xw_t  gx_d, gy_d, gx_q, gy_q;
  logic gv_q;

  // Q1.15 multiply by 1/K with round-half-up; |result| stays below 0.61 * full internal scale.
  assign gx_d = xw_t'((MW'(x_q[STAGES]) * K_GAIN + RND) >>> 15);
  assign gy_d = xw_t'((MW'(y_q[STAGES]) * K_GAIN + RND) >>> 15);

  always_ff @(posedge clk) begin
    if (rst) begin
      gx_q <= '0;
      gy_q <= '0;
      gv_q <= 1'b0;
    end else if (ce) begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      gv_q <= v_q[STAGES];
    end
  end

  assign fin_x = gx_q;
  assign fin_y = gy_q;
  assign fin_v = gv_q;
`else
  assign fin_x = x_q[STAGES];
  assign fin_y = y_q[STAGES];
  assign fin_v = v_q[STAGES];
`endif

  logic [DW-1:0] out_i_q, out_q_q;
  logic          rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_i_q <= '0;
      out_q_q <= '0;
      rdy_q   <= 1'b0;
    end else if (ce) begin
      rdy_q <= fin_v;
      if (fin_v) begin
        out_i_q <= sat(fin_x);
        out_q_q <= sat(fin_y);
      end
    end
  end

  assign dout_i   = out_i_q;
  assign dout_q   = out_q_q;
  assign dout_rdy = rdy_q;

endmodule
